// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C configuration sequencer: feed op codes,
// the sequencer state encoding, the byte-engine command fields and the
// helpers that build commands and size the shared timer.
package i2c_seq_pkg;

  localparam logic [1:0] OP_STOP     = 2'd0;
  localparam logic [1:0] OP_START    = 2'd1;
  localparam logic [1:0] OP_CONTINUE = 2'd2;
  localparam logic [1:0] OP_RESTART  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REWIND,
    ST_FETCH,
    ST_SETTLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_RECOVER,
    ST_BACKOFF,
    ST_DONE,
    ST_ERROR
  } seq_state_e;

  // One command to the byte engine; cmd_byte is only shifted out when byte_en is set.
  typedef struct packed {
    logic       stop;
    logic       start;
    logic       byte_en;
    logic [7:0] cmd_byte;
  } cmd_t;

  localparam cmd_t CMD_IDLE      = '{stop: 1'b0, start: 1'b0, byte_en: 1'b0, cmd_byte: 8'h00};
  localparam cmd_t CMD_STOP_ONLY = '{stop: 1'b1, start: 1'b0, byte_en: 1'b0, cmd_byte: 8'h00};

  // Translate a sampled feed step into the byte-engine command fields.
  function automatic cmd_t decode_cmd(input logic [1:0] op, input logic [7:0] data);
    cmd_t c;
    c.cmd_byte = data;
    case (op)
      OP_START:    begin c.stop = 1'b0; c.start = 1'b1; c.byte_en = 1'b1; end
      OP_CONTINUE: begin c.stop = 1'b0; c.start = 1'b0; c.byte_en = 1'b1; end
      OP_RESTART:  begin c.stop = 1'b1; c.start = 1'b1; c.byte_en = 1'b1; end
      default:     begin c.stop = 1'b1; c.start = 1'b0; c.byte_en = 1'b0; end
    endcase
    return c;
  endfunction

  // Width of the shared down-counter: wide enough for the longest load it can see.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// Loadable down-counter with a zero flag. One instance is shared by the
// settle delay, the retry backoff and the response watchdog; the sequencer
// never needs two of them at once.
module i2c_seq_timer #(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over counting; the counter parks at zero instead of wrapping.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/i2c_config_sequencer.sv
// I2C configuration sequencer for the HDMI transmitter bring-up path.
// Walks the register-initialisation feed one step per FeedUpdate pulse,
// turns each (Op, Data) pair into a byte-engine command, checks ACKs and
// restarts the whole sequence after a NACK with a backoff delay.
//
// Build option: define I2C_SEQ_TIMEOUT_EN to add a response watchdog of
// TIMEOUT_CYCLES; without it the sequencer waits for responses indefinitely.
module i2c_config_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int MAX_RETRIES    = 3,
  parameter int BACKOFF_CYCLES = 1000,
  parameter int BYTE_LIMIT     = 127,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  output logic       FeedUpdate,
  output logic       FeedReset_n,
  input  logic [1:0] FeedOp,
  input  logic [7:0] FeedData,
  output logic       CmdValid,
  input  logic       CmdReady,
  output logic       CmdStop,
  output logic       CmdStart,
  output logic       CmdByteEn,
  output logic [7:0] CmdByte,
  input  logic       RspValid,
  input  logic       RspAck,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic [3:0] RetryCount,
  output logic [6:0] ByteCount
);

  localparam int TW = timer_width(SETTLE_CYCLES, BACKOFF_CYCLES, TIMEOUT_CYCLES);

  seq_state_e state, next_state;
  cmd_t       cmd_q;      // command decoded from the last sampled feed step
  cmd_t       cmd_out;
  logic       err_flag;   // pass is doomed: recovery ends in ERROR, not a retry
  logic       rec_sent;   // RECOVER's stop-only command has been accepted

  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_zero;

  logic clr_status, set_done, set_error, set_err_flag;
  logic byte_inc, byte_clr, retry_inc, sample, rec_sent_set;

  i2c_seq_timer #(.W(TW)) u_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the per-cycle strobes that drive the datapath.
  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    next_state   = state;
    cmd_out      = CMD_IDLE;
    CmdValid     = 1'b0;
    FeedUpdate   = 1'b0;
    timer_load   = 1'b0;
    timer_val    = '0;
    clr_status   = 1'b0;
    set_done     = 1'b0;
    set_error    = 1'b0;
    set_err_flag = 1'b0;
    byte_inc     = 1'b0;
    byte_clr     = 1'b0;
    retry_inc    = 1'b0;
    sample       = 1'b0;
    rec_sent_set = 1'b0;

    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (Start) begin
          clr_status = 1'b1;
          next_state = ST_REWIND;
        end
      end

      ST_REWIND: next_state = ST_FETCH;

      ST_FETCH: begin
        // A feed that is still going after BYTE_LIMIT steps is runaway.
        if (ByteCount == 7'(BYTE_LIMIT)) begin
          set_err_flag = 1'b1;
          next_state   = ST_RECOVER;
        end else begin
          FeedUpdate = 1'b1;
          byte_inc   = 1'b1;
          timer_load = 1'b1;
          timer_val  = TW'(SETTLE_CYCLES - 1);
          next_state = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (timer_zero) begin
          sample     = 1'b1;
          next_state = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        CmdValid = 1'b1;
        cmd_out  = cmd_q;
        if (CmdReady) begin
          next_state = ST_WAIT_RSP;
`ifdef I2C_SEQ_TIMEOUT_EN
          timer_load = 1'b1;
          timer_val  = TW'(TIMEOUT_CYCLES);
`endif
        end
      end

      ST_WAIT_RSP: begin
        if (RspValid) begin
          if (!cmd_q.byte_en) begin
            set_done   = 1'b1;
            next_state = ST_DONE;
          end else if (RspAck) begin
            next_state = ST_FETCH;
          end else begin
            next_state = ST_RECOVER;
          end
        end
`ifdef I2C_SEQ_TIMEOUT_EN
        else if (timer_zero) begin
          set_err_flag = 1'b1;
          next_state   = ST_RECOVER;
        end
`endif
      end

      ST_RECOVER: begin
        // First release the bus with a stop-only command, then wait for its response.
        if (!rec_sent) begin
          CmdValid = 1'b1;
          cmd_out  = CMD_STOP_ONLY;
          if (CmdReady) begin
            rec_sent_set = 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
            timer_load = 1'b1;
            timer_val  = TW'(TIMEOUT_CYCLES);
`endif
          end
        end else if (RspValid) begin
          if (err_flag || (RetryCount == 4'(MAX_RETRIES))) begin
            set_error  = 1'b1;
            next_state = ST_ERROR;
          end else begin
            retry_inc  = 1'b1;
            timer_load = 1'b1;
            timer_val  = TW'(BACKOFF_CYCLES - 1);
            next_state = ST_BACKOFF;
          end
        end
`ifdef I2C_SEQ_TIMEOUT_EN
        else if (timer_zero) begin
          set_error  = 1'b1;
          next_state = ST_ERROR;
        end
`endif
      end

      ST_BACKOFF: begin
        if (timer_zero) begin
          byte_clr   = 1'b1;
          next_state = ST_REWIND;
        end
      end

      default: next_state = ST_IDLE;
    endcase
  end

  // Status, counters and the registered feed rewind strobe.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Done        <= 1'b0;
      Error       <= 1'b0;
      RetryCount  <= '0;
      ByteCount   <= '0;
      err_flag    <= 1'b0;
      rec_sent    <= 1'b0;
      FeedReset_n <= 1'b0;
    end else begin
      FeedReset_n <= (next_state != ST_REWIND);
      rec_sent    <= (next_state == ST_RECOVER) && (rec_sent || rec_sent_set);
      if (clr_status) begin
        Done       <= 1'b0;
        Error      <= 1'b0;
        RetryCount <= '0;
        ByteCount  <= '0;
        err_flag   <= 1'b0;
      end else begin
        if (set_done)     Done     <= 1'b1;
        if (set_error)    Error    <= 1'b1;
        if (set_err_flag) err_flag <= 1'b1;
        if (retry_inc && (RetryCount != 4'hF)) RetryCount <= RetryCount + 1'b1;
        if (byte_clr) begin
          ByteCount <= '0;
        end else if (byte_inc && (ByteCount != 7'h7F)) begin
          ByteCount <= ByteCount + 1'b1;
        end
      end
    end
  end

  // Capture the settled feed step.
  // NOTE: cmd_q has no reset; it is only visible on the bus after a sample has loaded it.
  always_ff @(posedge Clock) begin
    if (sample) begin
      cmd_q <= decode_cmd(FeedOp, FeedData);
    end
  end

  assign CmdStop   = cmd_out.stop;
  assign CmdStart  = cmd_out.start;
  assign CmdByteEn = cmd_out.byte_en;
  assign CmdByte   = cmd_out.cmd_byte;
  assign Busy      = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for i2c_config_sequencer: a feed model, a byte-engine model
// with configurable NACK/stall/withhold behaviour, and a linear test sequence.
module tb_i2c_config_sequencer;

  localparam int SETTLE  = 2;
  localparam int RETRIES = 2;
  localparam int BACKOFF = 20;
  localparam int LIMIT   = 10;
  localparam int TIMEOUT = 40;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic       FeedUpdate, FeedReset_n;
  logic [1:0] FeedOp;
  logic [7:0] FeedData;
  logic       CmdValid, CmdReady, CmdStop, CmdStart, CmdByteEn;
  logic [7:0] CmdByte;
  logic       RspValid = 1'b0;
  logic       RspAck = 1'b0;
  logic       Busy, Done, Error;
  logic [3:0] RetryCount;
  logic [6:0] ByteCount;

  always #5 Clock = ~Clock;

  i2c_config_sequencer #(
    .SETTLE_CYCLES  (SETTLE),
    .MAX_RETRIES    (RETRIES),
    .BACKOFF_CYCLES (BACKOFF),
    .BYTE_LIMIT     (LIMIT),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .FeedUpdate  (FeedUpdate),
    .FeedReset_n (FeedReset_n),
    .FeedOp      (FeedOp),
    .FeedData    (FeedData),
    .CmdValid    (CmdValid),
    .CmdReady    (CmdReady),
    .CmdStop     (CmdStop),
    .CmdStart    (CmdStart),
    .CmdByteEn   (CmdByteEn),
    .CmdByte     (CmdByte),
    .RspValid    (RspValid),
    .RspAck      (RspAck),
    .Busy        (Busy),
    .Done        (Done),
    .Error       (Error),
    .RetryCount  (RetryCount),
    .ByteCount   (ByteCount)
  );

  // ---------------- models ----------------
  logic [1:0]  op_tab  [0:15];
  logic [7:0]  dat_tab [0:15];
  logic [3:0]  feed_ptr = '0;
  logic [3:0]  feed_cur = '0;

  logic [10:0] log_f   [0:127];
  int          log_cyc [0:127];
  int          ncmd = 0;
  int          cyc = 0;
  int          n_rewind = 0;
  int          last_rewind_cyc = 0;
  int          unstable = 0;
  int          stall_run = 0;
  int          nacks_given = 0;
  logic        pending = 1'b0;
  logic        pend_ack = 1'b1;
  logic        held = 1'b0;
  logic [10:0] held_f = '0;
  logic [10:0] cmd_now;

  // configuration written only by the stimulus block
  int   nack_limit = 0;
  int   stall_at = -1;
  logic rsp_hold = 1'b0;

  assign FeedOp   = op_tab[feed_cur];
  assign FeedData = dat_tab[feed_cur];
  assign cmd_now  = {CmdStop, CmdStart, CmdByteEn, CmdByte};
  assign CmdReady = !((ncmd == stall_at) && (stall_run < 20));

  always @(posedge Clock) begin
    cyc      <= cyc + 1;
    RspValid <= 1'b0;
    if (Reset) begin
      pending  <= 1'b0;
      held     <= 1'b0;
      feed_ptr <= '0;
    end else begin
      if (!FeedReset_n) begin
        feed_ptr <= '0;
      end else if (FeedUpdate) begin
        feed_cur <= feed_ptr;
        feed_ptr <= feed_ptr + 4'd1;
      end
      if (!FeedReset_n && Busy) begin
        n_rewind        <= n_rewind + 1;
        last_rewind_cyc <= cyc;
      end
      if (held && !(CmdValid && (cmd_now == held_f))) unstable <= unstable + 1;
      held   <= CmdValid && !CmdReady;
      held_f <= cmd_now;
      if (CmdValid && !CmdReady) stall_run <= stall_run + 1;
      if (pending) begin
        RspValid <= 1'b1;
        RspAck   <= pend_ack;
        pending  <= 1'b0;
      end
      if (CmdValid && CmdReady) begin
        log_f[ncmd]   <= cmd_now;
        log_cyc[ncmd] <= cyc;
        ncmd          <= ncmd + 1;
        pending       <= !rsp_hold;
        if (CmdByteEn && (CmdByte == 8'h03) && (nacks_given < nack_limit)) begin
          pend_ack    <= 1'b0;
          nacks_given <= nacks_given + 1;
        end else begin
          pend_ack <= 1'b1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [27:0] outs();
    return {FeedReset_n, FeedUpdate, CmdValid, CmdStop, CmdStart, CmdByteEn, CmdByte,
            Busy, Done, Error, RetryCount, ByteCount};
  endfunction

  task automatic start_pass();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n;
    n = 0;
    while (!(!Busy && (Done || Error)) && (n < budget)) begin
      @(negedge Clock);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic load_clean();
    op_tab[0] = 2'd1; dat_tab[0] = 8'h72;
    op_tab[1] = 2'd2; dat_tab[1] = 8'h98;
    op_tab[2] = 2'd2; dat_tab[2] = 8'h03;
    op_tab[3] = 2'd3; dat_tab[3] = 8'h72;
    op_tab[4] = 2'd2; dat_tab[4] = 8'h01;
    op_tab[5] = 2'd2; dat_tab[5] = 8'h00;
    op_tab[6] = 2'd0; dat_tab[6] = 8'h00;
    for (int i = 7; i < 16; i++) begin
      op_tab[i] = 2'd0; dat_tab[i] = 8'h00;
    end
  endtask

  // expected {stop,start,byte_en,byte} for the clean 7-step feed
  logic [10:0] exp_clean [0:6];
  localparam logic [10:0] STOP_ONLY = 11'b100_0000_0000;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int base, rw;
    exp_clean[0] = {3'b011, 8'h72};
    exp_clean[1] = {3'b001, 8'h98};
    exp_clean[2] = {3'b001, 8'h03};
    exp_clean[3] = {3'b111, 8'h72};
    exp_clean[4] = {3'b001, 8'h01};
    exp_clean[5] = {3'b001, 8'h00};
    exp_clean[6] = {3'b100, 8'h00};
    load_clean();
    Reset = 1'b1;
    Start = 1'b0;

    // reset state
    repeat (3) @(negedge Clock);
    check("reset_outputs", 32'(outs()), 32'h0);
    Reset = 1'b0;
    @(negedge Clock);
    check("reset_release_feed_reset_n", 32'(FeedReset_n), 32'd1);
    check("reset_release_busy", 32'(Busy), 32'd0);

    // clean pass
    base = ncmd; rw = n_rewind;
    start_pass();
    wait_end("clean_end", 1000);
    check("clean_cmd_count", 32'(ncmd - base), 32'd7);
    for (int i = 0; i < 7; i++) check($sformatf("clean_cmd%0d", i), 32'(log_f[base+i]), 32'(exp_clean[i]));
    check("clean_done", 32'(Done), 32'd1);
    check("clean_error", 32'(Error), 32'd0);
    check("clean_busy", 32'(Busy), 32'd0);
    check("clean_byte_count", 32'(ByteCount), 32'd7);
    check("clean_retry_count", 32'(RetryCount), 32'd0);
    check("clean_rewinds", 32'(n_rewind - rw), 32'd1);

    // single NACK on the third byte
    nack_limit = nacks_given + 1;
    base = ncmd; rw = n_rewind;
    start_pass();
    wait_end("nack1_end", 2000);
    check("nack1_cmd_count", 32'(ncmd - base), 32'd11);
    check("nack1_recover_cmd", 32'(log_f[base+3]), 32'(STOP_ONLY));
    for (int i = 0; i < 7; i++) check($sformatf("nack1_replay%0d", i), 32'(log_f[base+4+i]), 32'(exp_clean[i]));
    // stop accepted -> response 2 edges later -> BACKOFF cycles -> rewind seen 1 edge after
    check("nack1_backoff_gap", 32'(last_rewind_cyc - log_cyc[base+3]), 32'(BACKOFF + 3));
    check("nack1_rewinds", 32'(n_rewind - rw), 32'd2);
    check("nack1_done", 32'(Done), 32'd1);
    check("nack1_retry_count", 32'(RetryCount), 32'd1);
    check("nack1_byte_count", 32'(ByteCount), 32'd7);

    // persistent NACK: MAX_RETRIES=2 gives 3 attempts
    nack_limit = nacks_given + 1000;
    base = ncmd; rw = n_rewind;
    start_pass();
    wait_end("nackp_end", 3000);
    nack_limit = nacks_given;
    check("nackp_cmd_count", 32'(ncmd - base), 32'd12);
    check("nackp_attempts", 32'(n_rewind - rw), 32'd3);
    check("nackp_last_cmd", 32'(log_f[base+11]), 32'(STOP_ONLY));
    check("nackp_error", 32'(Error), 32'd1);
    check("nackp_done", 32'(Done), 32'd0);
    check("nackp_busy", 32'(Busy), 32'd0);
    check("nackp_retry_count", 32'(RetryCount), 32'd2);

    // CmdReady held low for 20 cycles on the second command
    base = ncmd;
    stall_at = base + 1;
    start_pass();
    wait_end("stall_end", 1000);
    check("stall_cycles", 32'(stall_run), 32'd20);
    check("stall_unstable", 32'(unstable), 32'd0);
    check("stall_cmd_count", 32'(ncmd - base), 32'd7);
    check("stall_cmd1", 32'(log_f[base+1]), 32'(exp_clean[1]));
    check("stall_done", 32'(Done), 32'd1);

    // reset while waiting for a response
    rsp_hold = 1'b1;
    base = ncmd;
    start_pass();
    for (int n = 0; n < 200 && ncmd == base; n++) @(negedge Clock);
    check("rstmid_first_cmd", 32'(ncmd - base), 32'd1);
    repeat (3) @(negedge Clock);
    check("rstmid_busy_before", 32'(Busy), 32'd1);
    check("rstmid_byte_count_before", 32'(ByteCount), 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    check("rstmid_outputs", 32'(outs()), 32'h0);
    Reset = 1'b0;
    rsp_hold = 1'b0;
    @(negedge Clock);
    check("rstmid_feed_reset_n", 32'(FeedReset_n), 32'd1);
    base = ncmd;
    start_pass();
    wait_end("rstmid_pass_end", 1000);
    check("rstmid_pass_cmds", 32'(ncmd - base), 32'd7);
    check("rstmid_pass_done", 32'(Done), 32'd1);

    // feed never returns STOP: BYTE_LIMIT=10
    op_tab[0] = 2'd1; dat_tab[0] = 8'hA0;
    for (int i = 1; i < 16; i++) begin
      op_tab[i] = 2'd2; dat_tab[i] = 8'(8'h10 + i);
    end
    base = ncmd;
    start_pass();
    wait_end("limit_end", 1000);
    check("limit_cmd_count", 32'(ncmd - base), 32'd11);
    check("limit_last_cmd", 32'(log_f[base+10]), 32'(STOP_ONLY));
    check("limit_error", 32'(Error), 32'd1);
    check("limit_done", 32'(Done), 32'd0);
    check("limit_byte_count", 32'(ByteCount), 32'd10);
    check("limit_retry_count", 32'(RetryCount), 32'd0);

`ifdef I2C_SEQ_TIMEOUT_EN
    // responses withheld: watchdog in WAIT_RSP, then again in RECOVER
    load_clean();
    rsp_hold = 1'b1;
    base = ncmd;
    rw = cyc;
    start_pass();
    wait_end("timeout_end", 1000);
    rsp_hold = 1'b0;
    check("timeout_error", 32'(Error), 32'd1);
    check("timeout_cmd_count", 32'(ncmd - base), 32'd2);
    check("timeout_recover_cmd", 32'(log_f[base+1]), 32'(STOP_ONLY));
    check("timeout_elapsed", 32'((cyc - rw) >= 2 * TIMEOUT), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
